shift_reg_univ: RTL and testbench

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_univ_pkg.sv | 20 ++
 rtl/shift_reg_cell.sv | 42 ++++
 rtl/shift_reg_univ.sv | 121 ++++++++++++
 tb/tb_shift_reg_univ.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_univ_pkg.sv
// ----------------------------------------------------------------------------
// shift_reg_univ_pkg
// Shared definitions for the universal shift register slice.
//   MODE_W  : width of the operation select field
//   mode_e  : operation encodings (hold, shift right, shift left, load)
// The encodings double as the select index of the per-bit 4:1 mux, so the
// order of the enum values must match the mux input order in shift_reg_univ.
// ----------------------------------------------------------------------------
package shift_reg_univ_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_reg_cell.sv
// ----------------------------------------------------------------------------
// shift_reg_cell
// One bit of the universal shift register: a flip-flop fed by a 4:1 mux.
// Ports:
//   clk_i    : rising-edge clock
//   reset_i  : synchronous active-high reset, clears the bit
//   enable_i : update qualifier, the bit holds when low
//   sel_i    : mux select (a mode encoding from shift_reg_univ_pkg)
//   data_i   : the four candidate next values, indexed by sel_i
//   q_o      : registered bit
// ----------------------------------------------------------------------------
module shift_reg_cell
  import shift_reg_univ_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [MODE_W-1:0] sel_i,
  input  logic [3:0]        data_i,
  output logic              q_o
);

  logic bit_q;
  logic bit_d;

  // Pick the candidate next value for this bit straight from the select.
  always_comb begin
    bit_d = data_i[sel_i];
  end

  // Reset wins over enable; with enable low the bit simply keeps its value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_q <= 1'b0;
    end else if (enable_i) begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/shift_reg_univ.sv
// ----------------------------------------------------------------------------
// shift_reg_univ
// Universal shift register: hold, shift right, shift left or parallel load,
// plus a saturating shift counter that raises done after WIDTH shifts since
// the last load or reset.
// Parameters:
//   WIDTH : register width (2..64)
//   CNT_W : shift counter width
// Ports:
//   CLK    : rising-edge clock
//   reset  : synchronous active-high reset (Q, counter and done to 0)
//   enable : global update qualifier
//   mode   : 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D      : parallel load data
//   sin_r  : serial input entering the MSB on a right shift
//   sin_l  : serial input entering the LSB on a left shift
//   rot    : (only with SHIFT_REG_UNIV_ROTATE_EN) rotate instead of shift
//   Q      : registered contents
//   sout_r : Q[0]
//   sout_l : Q[WIDTH-1]
//   done   : registered, high once WIDTH shifts have happened
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN adds the rot input.
// ----------------------------------------------------------------------------
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              sin_r,
  input  logic              sin_l,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic              rot,
`endif
  output logic [WIDTH-1:0]  Q,
  output logic              sout_r,
  output logic              sout_l,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] qBus;
  logic [WIDTH-1:0] shrNext;
  logic [WIDTH-1:0] shlNext;
  logic             rightIn;
  logic             leftIn;
  mode_e            modeSel;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;

  assign modeSel = mode_e'(mode);

  // Bits entering at the ends of the register; rotation feeds the opposite
  // end of Q back in instead of the serial inputs.
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign rightIn = rot ? qBus[0]       : sin_r;
  assign leftIn  = rot ? qBus[WIDTH-1] : sin_l;
`else
  assign rightIn = sin_r;
  assign leftIn  = sin_l;
`endif

  assign shrNext = {rightIn, qBus[WIDTH-1:1]};
  assign shlNext = {qBus[WIDTH-2:0], leftIn};

  // One cell per bit; the mux inputs are ordered so the mode encoding is the
  // select index directly (0 hold, 1 right, 2 left, 3 load).
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_cell u_cell (
      .clk_i    (CLK),
      .reset_i  (reset),
      .enable_i (enable),
      .sel_i    (mode),
      .data_i   ({D[i], shlNext[i], shrNext[i], qBus[i]}),
      .q_o      (qBus[i])
    );
  end

  // Counter next state: loads clear it, shifts count up and stick at WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      case (modeSel)
        MODE_SHR, MODE_SHL: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_LOAD: cnt_d = '0;
        default:   cnt_d = cnt_q;
      endcase
    end
    done_d = (cnt_d == CNT_MAX);
  end

  // done is registered alongside the counter so it always matches it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q      = qBus;
  assign sout_r = qBus[0];
  assign sout_l = qBus[WIDTH-1];
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// ----------------------------------------------------------------------------
// tb_shift_reg_univ
// Directed self-checking bench for shift_reg_univ at WIDTH=4. Each step
// drives inputs, advances a small reference model and queues the expected
// post-edge state; after the edge the entry is popped and compared.
// Define SHIFT_REG_UNIV_ROTATE_EN to also exercise the rot input.
// ----------------------------------------------------------------------------
module tb_shift_reg_univ;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             done;
  } exp_t;

  logic             CLK;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin_r;
  logic             sin_l;
  logic             rot;
  logic [WIDTH-1:0] Q;
  logic             sout_r;
  logic             sout_l;
  logic             done;

  exp_t             expQueue[$];
  logic [WIDTH-1:0] modelQ;
  int               modelCnt;
  int               checks;
  int               errors;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .D      (D),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot    (rot),
`endif
    .Q      (Q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .done   (done)
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case something stalls the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, update the reference model, queue the
  // expected result, then let the edge happen and sample 1 unit later.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [1:0] md, input logic [WIDTH-1:0] d,
                               input logic sr, input logic sl, input logic rt);
    logic inR;
    logic inL;
    exp_t e;
    reset  = rst;
    enable = en;
    mode   = md;
    D      = d;
    sin_r  = sr;
    sin_l  = sl;
    rot    = rt;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    inR = rt ? modelQ[0] : sr;
    inL = rt ? modelQ[WIDTH-1] : sl;
`else
    inR = sr;
    inL = sl;
`endif
    if (rst) begin
      modelQ   = '0;
      modelCnt = 0;
    end else if (en) begin
      case (md)
        2'b01: begin
          modelQ   = {inR, modelQ[WIDTH-1:1]};
          modelCnt = (modelCnt < WIDTH) ? modelCnt + 1 : WIDTH;
        end
        2'b10: begin
          modelQ   = {modelQ[WIDTH-2:0], inL};
          modelCnt = (modelCnt < WIDTH) ? modelCnt + 1 : WIDTH;
        end
        2'b11: begin
          modelQ   = d;
          modelCnt = 0;
        end
        default: ;
      endcase
    end
    e.q    = modelQ;
    e.done = (modelCnt == WIDTH);
    expQueue.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Pop the oldest expectation and compare Q, done and both serial outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (expQueue.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      checks++;
      assert (Q === e.q) else begin
        errors++;
        $error("[TB] FAIL %s_q observed=%b expected=%b", tag, Q, e.q);
      end
      checks++;
      assert (done === e.done) else begin
        errors++;
        $error("[TB] FAIL %s_done observed=%b expected=%b", tag, done, e.done);
      end
      checks++;
      assert (sout_r === e.q[0]) else begin
        errors++;
        $error("[TB] FAIL %s_sout_r observed=%b expected=%b", tag, sout_r, e.q[0]);
      end
      checks++;
      assert (sout_l === e.q[WIDTH-1]) else begin
        errors++;
        $error("[TB] FAIL %s_sout_l observed=%b expected=%b", tag, sout_l, e.q[WIDTH-1]);
      end
    end
  endtask

  // Compare Q and done against literal values written out in the sequence.
  task automatic checkLiteral(input string tag, input logic [WIDTH-1:0] q,
                              input logic dn);
    checks++;
    assert (Q === q) else begin
      errors++;
      $error("[TB] FAIL %s_lit_q observed=%b expected=%b", tag, Q, q);
    end
    checks++;
    assert (done === dn) else begin
      errors++;
      $error("[TB] FAIL %s_lit_done observed=%b expected=%b", tag, done, dn);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    modelQ   = '0;
    modelCnt = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    mode     = 2'b00;
    D        = '0;
    sin_r    = 1'b0;
    sin_l    = 1'b0;
    rot      = 1'b0;
    @(negedge CLK);

    // Reset for one edge.
    applyStimulus(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    checkLiteral("reset", 4'b0000, 1'b0);

    // Parallel load.
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0);
    checkOutput("load");
    checkLiteral("load", 4'b1010, 1'b0);

    // Four right shifts with sin_r=1; done rises only after the fourth.
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shr1");
    checkLiteral("shr1", 4'b1101, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shr2");
    checkLiteral("shr2", 4'b1110, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shr3");
    checkLiteral("shr3", 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shr4");
    checkLiteral("shr4", 4'b1111, 1'b1);

    // Enable low blocks a load for three edges.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 4'b0101, 1'b0, 1'b1, 1'b0);
      checkOutput("enlow");
      checkLiteral("enlow", 4'b1111, 1'b1);
    end

    // Shifting past saturation keeps done high.
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shl_sat");
    checkLiteral("shl_sat", 4'b1110, 1'b1);

    // A load clears done.
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("load2");
    checkLiteral("load2", 4'b0001, 1'b0);

    // Two left shifts reach 0110, then reset beats an enabled load.
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("shl_a");
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("shl_b");
    checkLiteral("shl_b", 4'b0110, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_prio");
    checkLiteral("rst_prio", 4'b0000, 1'b0);

    // Mixed shifts count together; an enabled hold does not count.
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("mix1");
    checkLiteral("mix1", 4'b1000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("mix2");
    checkLiteral("mix2", 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b1111, 1'b0, 1'b1, 1'b0);
    checkOutput("mix3");
    checkLiteral("mix3", 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 1'b0);
    checkOutput("hold");
    checkLiteral("hold", 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("mix4");
    checkLiteral("mix4", 4'b0001, 1'b1);

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotation ignores the serial inputs and still counts.
    applyStimulus(1'b0, 1'b1, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("rot_load");
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("rotl");
    checkLiteral("rotl", 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b1);
    checkOutput("rotr1");
    checkLiteral("rotr1", 4'b1000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b1);
    checkOutput("rotr2");
    checkLiteral("rotr2", 4'b0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b1);
    checkOutput("rotr3");
    checkLiteral("rotr3", 4'b0010, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
